// File: rtl/pos_tracker_pkg.sv
// Shared constants for the position tracker: status byte layout and the
// quadrature phase encoding used by both encoder axes.
package pos_tracker_pkg;

  localparam int STS_BTN     = 7;
  localparam int STS_XERR    = 6;
  localparam int STS_YERR    = 5;
  localparam int STS_XOVF    = 4;
  localparam int STS_YOVF    = 3;
  localparam int STS_MOVED   = 2;
  localparam int STS_SEQ_LSB = 0;

  // Forward rotation walks P0 -> P1 -> P2 -> P3 -> P0
  localparam logic [1:0] AB_P0 = 2'b00;
  localparam logic [1:0] AB_P1 = 2'b01;
  localparam logic [1:0] AB_P2 = 2'b11;
  localparam logic [1:0] AB_P3 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_BAD  = 2'd3
  } step_e;

  function automatic logic [1:0] ab_next(input logic [1:0] ab);
    case (ab)
      AB_P0:   return AB_P1;
      AB_P1:   return AB_P2;
      AB_P2:   return AB_P3;
      default: return AB_P0;
    endcase
  endfunction

endpackage

// File: rtl/quad_axis.sv
// One encoder axis: 2-flop synchroniser, x4 quadrature decode against the
// previous AB, and an 8-bit saturating or wrapping position counter.
module quad_axis
  import pos_tracker_pkg::*;
#(
  parameter logic [7:0] INIT_POS = 8'd128,
  parameter bit         SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       recenter,
  output logic [7:0] pos,
  output logic       step_pulse,
  output logic       err_pulse,
  output logic       ovf_pulse
);

  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [7:0] pos_q, pos_d;
  step_e      step;

  always_comb begin
    sync1_d = {a, b};
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    step = STEP_NONE;
    if (sync2_q != prev_q) begin
      if (sync2_q == ab_next(prev_q))      step = STEP_FWD;
      else if (prev_q == ab_next(sync2_q)) step = STEP_REV;
      else                                 step = STEP_BAD;
    end

    pos_d      = pos_q;
    step_pulse = 1'b0;
    err_pulse  = 1'b0;
    ovf_pulse  = 1'b0;
    // Recenter overrides any step in the same cycle and suppresses its flags
    if (recenter) begin
      pos_d = INIT_POS;
    end else begin
      case (step)
        STEP_FWD: begin
          step_pulse = 1'b1;
          if (pos_q == 8'hFF) begin
            ovf_pulse = 1'b1;
            pos_d     = SATURATE ? 8'hFF : 8'h00;
          end else begin
            pos_d = pos_q + 8'd1;
          end
        end
        STEP_REV: begin
          step_pulse = 1'b1;
          if (pos_q == 8'h00) begin
            ovf_pulse = 1'b1;
            pos_d     = SATURATE ? 8'h00 : 8'hFF;
          end else begin
            pos_d = pos_q - 8'd1;
          end
        end
        STEP_BAD: err_pulse = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
      pos_q   <= INIT_POS;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/pos_tracker.sv
// Two-axis encoder + button tracker; a snapshot strobe latches a coherent
// {x_pos, y_pos, status} triple for the I2C slave to stream out.
module pos_tracker
  import pos_tracker_pkg::*;
#(
  parameter logic [7:0] INIT_POS        = 8'd128,
  parameter bit         SATURATE        = 1'b1,
  parameter int         DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enc_x_a,
  input  logic       enc_x_b,
  input  logic       enc_y_a,
  input  logic       enc_y_b,
  input  logic       btn_in,
  input  logic       recenter,
  input  logic       snap_req,
  output logic [7:0] x_pos,
  output logic [7:0] y_pos,
  output logic [7:0] status
);

  logic [7:0]  x_live, y_live;
  logic        x_step, x_err, x_ovf, y_step, y_err, y_ovf;
  logic        btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_state_q, btn_state_d;
  logic [15:0] dbc_q, dbc_d;
  logic [4:0]  flags_q, flags_d, events;
  logic [1:0]  seq_q, seq_d;
  logic [7:0]  x_pos_q, x_pos_d, y_pos_q, y_pos_d, status_q, status_d, sts_now;

  quad_axis #(.INIT_POS(INIT_POS), .SATURATE(SATURATE)) u_x (
    .clk(clk), .rst_n(rst_n), .a(enc_x_a), .b(enc_x_b), .recenter(recenter),
    .pos(x_live), .step_pulse(x_step), .err_pulse(x_err), .ovf_pulse(x_ovf)
  );

  quad_axis #(.INIT_POS(INIT_POS), .SATURATE(SATURATE)) u_y (
    .clk(clk), .rst_n(rst_n), .a(enc_y_a), .b(enc_y_b), .recenter(recenter),
    .pos(y_live), .step_pulse(y_step), .err_pulse(y_err), .ovf_pulse(y_ovf)
  );

  // flags_q order {x_err, y_err, x_ovf, y_ovf, moved} mirrors status[6:2]
  assign events = {x_err, y_err, x_ovf, y_ovf, x_step | y_step};

  always_comb begin
    btn_s1_d    = btn_in;
    btn_s2_d    = btn_s1_q;
    btn_state_d = btn_state_q;
    dbc_d       = 16'd0;
    if (btn_s2_q != btn_state_q) begin
      if (dbc_q == 16'(DEBOUNCE_CYCLES - 1)) btn_state_d = ~btn_state_q;
      else                                   dbc_d       = dbc_q + 16'd1;
    end

    sts_now                            = 8'h00;
    sts_now[STS_BTN]                   = btn_state_q;
    sts_now[STS_XERR]                  = flags_q[4];
    sts_now[STS_YERR]                  = flags_q[3];
    sts_now[STS_XOVF]                  = flags_q[2];
    sts_now[STS_YOVF]                  = flags_q[1];
    sts_now[STS_MOVED]                 = flags_q[0];
    sts_now[STS_SEQ_LSB+1:STS_SEQ_LSB] = seq_q;

    // Same-cycle event survives the snapshot clear
    flags_d  = (snap_req ? 5'd0 : flags_q) | events;
    seq_d    = snap_req ? seq_q + 2'd1 : seq_q;
    x_pos_d  = snap_req ? x_live  : x_pos_q;
    y_pos_d  = snap_req ? y_live  : y_pos_q;
    status_d = snap_req ? sts_now : status_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      btn_state_q <= 1'b0;
      dbc_q       <= 16'd0;
      flags_q     <= 5'd0;
      seq_q       <= 2'd0;
      x_pos_q     <= INIT_POS;
      y_pos_q     <= INIT_POS;
      status_q    <= 8'h00;
    end else begin
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      btn_state_q <= btn_state_d;
      dbc_q       <= dbc_d;
      flags_q     <= flags_d;
      seq_q       <= seq_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      status_q    <= status_d;
    end
  end

  assign x_pos  = x_pos_q;
  assign y_pos  = y_pos_q;
  assign status = status_q;

endmodule

// File: tb/tb_pos_tracker.sv
// Drives a saturating and a wrapping pos_tracker with the same stimulus and
// compares every cycle against a phase-arithmetic reference model.
module tb_pos_tracker;

  localparam int DEB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1, enc_x_a = 1'b0, enc_x_b = 1'b0, enc_y_a = 1'b0, enc_y_b = 1'b0;
  logic btn_in = 1'b0, recenter = 1'b0, snap_req = 1'b0;
  logic [7:0] xs, ys, sts, xw, yw, stw;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  int xi = 0, yi = 0;

  always #5 clk = ~clk;

  pos_tracker #(.INIT_POS(8'd128), .SATURATE(1'b1), .DEBOUNCE_CYCLES(DEB)) u_s (
    .clk(clk), .rst_n(rst_n), .enc_x_a(enc_x_a), .enc_x_b(enc_x_b),
    .enc_y_a(enc_y_a), .enc_y_b(enc_y_b), .btn_in(btn_in), .recenter(recenter),
    .snap_req(snap_req), .x_pos(xs), .y_pos(ys), .status(sts)
  );

  pos_tracker #(.INIT_POS(8'd128), .SATURATE(1'b0), .DEBOUNCE_CYCLES(DEB)) u_w (
    .clk(clk), .rst_n(rst_n), .enc_x_a(enc_x_a), .enc_x_b(enc_x_b),
    .enc_y_a(enc_y_a), .enc_y_b(enc_y_b), .btn_in(btn_in), .recenter(recenter),
    .snap_req(snap_req), .x_pos(xw), .y_pos(yw), .status(stw)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pins are seen two samples late; steps are phase-index deltas
  typedef struct packed {
    logic [7:0]  px, py, ox, oy, ost;
    logic [5:0]  hx, hy;
    logic [2:0]  hb;
    logic        ex, ey, vx, vy, mv, bst;
    logic [1:0]  seq;
    logic [15:0] run;
  } mdl_t;

  mdl_t m [2];

  function automatic int ph(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray(input int i);
    case (i & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // returns {pos, moved, err, ovf}
  function automatic logic [10:0] axis(input logic [7:0] p, input logic [1:0] nw,
                                       input logic [1:0] od, input logic rc, input logic sat);
    int d, v;
    if (rc) return {8'h80, 3'b000};
    d = (ph(nw) - ph(od)) & 3;
    if (d == 2) return {p, 3'b010};
    if (d == 0) return {p, 3'b000};
    v = int'(p) + ((d == 1) ? 1 : -1);
    if (v > 255) return {(sat ? 8'hFF : 8'h00), 3'b101};
    if (v < 0)   return {(sat ? 8'h00 : 8'hFF), 3'b101};
    return {8'(v), 3'b100};
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input logic sat, input logic rst,
                                 input logic [1:0] xab, input logic [1:0] yab,
                                 input logic btn, input logic rc, input logic snap);
    mdl_t n;
    logic [10:0] rx, ry;
    n = c;
    if (!rst) begin
      n = '0;
      n.px = 8'h80; n.py = 8'h80; n.ox = 8'h80; n.oy = 8'h80;
      return n;
    end
    if (snap) begin
      n.ox  = c.px;
      n.oy  = c.py;
      n.ost = {c.bst, c.ex, c.ey, c.vx, c.vy, c.mv, c.seq};
      n.seq = c.seq + 2'd1;
      {n.ex, n.ey, n.vx, n.vy, n.mv} = 5'd0;
    end
    rx = axis(c.px, c.hx[3:2], c.hx[5:4], rc, sat);
    ry = axis(c.py, c.hy[3:2], c.hy[5:4], rc, sat);
    n.px = rx[10:3];
    n.py = ry[10:3];
    n.ex |= rx[1]; n.ey |= ry[1]; n.vx |= rx[0]; n.vy |= ry[0];
    n.mv |= rx[2] | ry[2];
    if (c.hb[1] == c.bst) n.run = 16'd0;
    else if (int'(c.run) + 1 == DEB) begin n.bst = ~c.bst; n.run = 16'd0; end
    else n.run = c.run + 16'd1;
    n.hx = {c.hx[3:0], xab};
    n.hy = {c.hy[3:0], yab};
    n.hb = {c.hb[1:0], btn};
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      m[i] <= mstep(m[i], (i == 0), rst_n, {enc_x_a, enc_x_b}, {enc_y_a, enc_y_b},
                    btn_in, recenter, snap_req);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_x", xs, m[0].ox);  chk("s_y", ys, m[0].oy);  chk("s_st", sts, m[0].ost);
      chk("w_x", xw, m[1].ox);  chk("w_y", yw, m[1].oy);  chk("w_st", stw, m[1].ost);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_pins();
    {enc_x_a, enc_x_b} = gray(xi);
    {enc_y_a, enc_y_b} = gray(yi);
  endtask

  task automatic do_reset();
    xi = 0; yi = 0; drive_pins();
    rst_n = 1'b0; ticks(2); rst_n = 1'b1;
  endtask

  task automatic snap();
    snap_req = 1'b1; tick(); snap_req = 1'b0;
  endtask

  logic [7:0] bit_s;

  initial begin
    drive_pins();
    rst_n = 1'b0; tick(); chk_en = 1'b1; tick(); rst_n = 1'b1;
    chk("rst_x", xs, 8'h80); chk("rst_y", ys, 8'h80); chk("rst_st", sts, 8'h00);
    snap();
    chk("snap0_x", xs, 8'h80); chk("snap0_st", sts, 8'h00);
    snap();
    chk("snap1_st", sts, 8'h01);

    // X forward 4 steps
    do_reset();
    for (int i = 0; i < 4; i++) begin xi++; drive_pins(); ticks(4); end
    snap();
    chk("fwd_x", xs, 8'h84); chk("fwd_y", ys, 8'h80); chk("fwd_st", sts, 8'h04);
    snap();
    chk("fwd_st2", sts, 8'h01);

    // clamp / wrap
    recenter = 1'b1; tick(); recenter = 1'b0;
    snap();
    for (int i = 0; i < 128; i++) begin xi++; drive_pins(); ticks(2); end
    ticks(3); snap();
    chk("sat_x", xs, 8'hFF); bit_s = {7'd0, sts[4]}; chk("sat_ovf", bit_s, 8'h01);
    chk("wrap_x", xw, 8'h00); bit_s = {7'd0, stw[4]}; chk("wrap_ovf", bit_s, 8'h01);
    for (int i = 0; i < 2; i++) begin xi++; drive_pins(); ticks(2); end
    ticks(3); snap();
    chk("sat_x2", xs, 8'hFF); chk("wrap_x2", xw, 8'h02);

    // Illegal Y 00 -> 11
    do_reset(); snap();
    yi = 2; drive_pins(); ticks(4); snap();
    chk("ill_y", ys, 8'h80);
    bit_s = {7'd0, sts[5]}; chk("ill_yerr", bit_s, 8'h01);
    bit_s = {7'd0, sts[2]}; chk("ill_moved", bit_s, 8'h00);

    // Debounce
    btn_in = 1'b1; ticks(5); btn_in = 1'b0; ticks(12); snap();
    bit_s = {7'd0, sts[7]}; chk("deb_short", bit_s, 8'h00);
    btn_in = 1'b1; ticks(20); snap();
    bit_s = {7'd0, sts[7]}; chk("deb_long", bit_s, 8'h01);
    btn_in = 1'b0; ticks(14);

    // Step lands on the same edge as snap_req
    do_reset(); snap();
    xi++; drive_pins(); ticks(2); snap();
    bit_s = {7'd0, sts[2]}; chk("sim_moved0", bit_s, 8'h00); chk("sim_x0", xs, 8'h80);
    snap();
    bit_s = {7'd0, sts[2]}; chk("sim_moved1", bit_s, 8'h01); chk("sim_x1", xs, 8'h81);

    // Random walk, including resets, recenter and illegal jumps
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) xi++; else if (r < 20) xi--; else if (r == 20) xi += 2;
      r = $urandom_range(0, 99);
      if (r < 10) yi++; else if (r < 20) yi--; else if (r == 20) yi += 2;
      drive_pins();
      if ($urandom_range(0, 19) == 0) btn_in = ~btn_in;
      recenter = ($urandom_range(0, 49) == 0);
      snap_req = ($urandom_range(0, 9) == 0);
      rst_n    = ($urandom_range(0, 499) != 0);
      tick();
    end
    // Biased walk to reach the clamp/wrap boundaries
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 4) xi++;
      if ($urandom_range(0, 9) < 4) yi--;
      drive_pins();
      recenter = ($urandom_range(0, 399) == 0);
      snap_req = ($urandom_range(0, 7) == 0);
      tick();
    end
    recenter = 1'b0; snap_req = 1'b0;
    ticks(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pos_tracker.md
Name: pos_tracker

Overview:
- Upstream producer for the I2C read-only slave.
- Decodes two quadrature encoders (X, Y) and one push-button into live 8-bit positions and sticky event flags.
- On a snapshot strobe, issued by the integration at each I2C START, it latches a coherent {x_pos, y_pos, status} triple. The slave can then stream all three bytes without them changing mid-read.

Parameters:
- INIT_POS, 8'd128, reset and recenter value of both live counters.
- SATURATE, 1, 1 = clamp at 0/255; 0 = wrap modulo 256.
- DEBOUNCE_CYCLES, 1000, number of consecutive stable clk cycles required before the button state is accepted (1..65535).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enc_x_a  in  1  X encoder phase A, asynchronous.
- enc_x_b  in  1  X encoder phase B, asynchronous.
- enc_y_a  in  1  Y encoder phase A, asynchronous.
- enc_y_b  in  1  Y encoder phase B, asynchronous.
- btn_in  in  1  push-button, asynchronous, active-high.
- recenter  in  1  synchronous pulse; resets both live counters to INIT_POS.
- snap_req  in  1  single-cycle snapshot strobe.
- x_pos  out  8  snapshot X position.
- y_pos  out  8  snapshot Y position.
- status  out  8  snapshot status byte.

Behaviour:
- Reset: applied only on a clk edge with rst_n=0. It clears:
  - live counters to INIT_POS;
  - x_pos and y_pos to INIT_POS;
  - status to 8'h00;
  - sync flops, debounce counter, sticky flags and snap_seq to 0.
- Reset mid-operation discards any partial debounce or in-flight edge.
- Synchronisers: every asynchronous input passes through 2 flops. The decoder compares the second stage against a registered previous AB.
- Quadrature decode, per axis, with AB transitions counted at x4 resolution:
  - +1 on 00→01, 01→11, 11→10, 10→00.
  - −1 on the reverse sequence.
  - No change when AB is unchanged.
  - A two-bit change (00↔11, 01↔10) is illegal: no count, and the axis err flag is set.
- Latency: a pin edge is reflected in the live counter on the 3rd rising clk after it is sampled.
- Arithmetic: the counter is 8 bits unsigned.
  - SATURATE=1: +1 at 255 stays at 255; −1 at 0 stays at 0. Either clamp sets the axis ovf flag.
  - SATURATE=0: the counter wraps 255→0 and 0→255, and the wrap sets the axis ovf flag.
- Any legal step on either axis sets the moved flag.
- recenter: live counters load INIT_POS. If recenter coincides with a step, recenter wins, the step is dropped and no flag is set.
- Button debounce:
  - A counter increments while the synced btn ≠ btn_state and resets to 0 whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES−1, btn_state toggles and the counter clears.
  - btn_state is a level, not sticky.
- Sticky flags (x_err, y_err, x_ovf, y_ovf, moved):
  - Set on event.
  - Cleared only by snap_req or reset.
  - If an event occurs in the same cycle as snap_req: the snapshot captures the pre-event value, and the flag is left set afterwards (set wins over clear).
- Snapshot: on the cycle snap_req=1, the following load on the next edge:
  - x_pos and y_pos load the current live counters.
  - status loads {btn_state, x_err, y_err, x_ovf, y_ovf, moved, snap_seq[1:0]}, where snap_seq is the value before the increment.
  - snap_seq increments, wrapping 3→0.
- Back-to-back snap_req pulses are each honoured.
- Outputs are registered and change only on snap_req or reset, never while snap_req=0.

Decomposition:
- Package pos_tracker_pkg holds:
  - status bit indices: STS_BTN=7, STS_XERR=6, STS_YERR=5, STS_XOVF=4, STS_YOVF=3, STS_MOVED=2, STS_SEQ_LSB=0;
  - the 2-bit AB phase encoding constants.
- Sub-module quad_axis, instantiated twice, contains:
  - the synchroniser, previous-AB register and step/illegal decode;
  - the saturating/wrapping counter with recenter.
- quad_axis outputs: pos[7:0], step_pulse, err_pulse and ovf_pulse.
- The top level holds the button debounce, sticky flags and the snapshot register.

Test Plan:
- Reset: hold rst_n=0 for 2 clk, then release → x_pos=y_pos=0x80 and status=0x00; snap_req → same values, then status[1:0]=1 on the next snapshot.
- X forward: 4 legal forward AB steps spaced 4 clk apart, then snap_req → x_pos=0x84, y_pos=0x80, status=0x04; a second snap_req → status=0x01 (moved cleared, seq=1).
- Saturation, SATURATE=1: recenter, then 130 forward X steps, then snap → x_pos=0xFF with x_ovf set (status bit4=1). Repeat with SATURATE=0 and 128 steps → x_pos=0x00, ovf set.
- Illegal transition: drive Y AB 00→11 directly, then snap → y_pos unchanged (0x80), y_err set (status bit5=1), moved=0.
- Debounce, DEBOUNCE_CYCLES=8: press btn for 5 cycles then release, snap → bit7=0. Press for 20 cycles, snap → bit7=1, and the outputs stay unchanged during the press until snap.
- Simultaneous events: a step and snap_req on the same cycle → snapshot shows moved=0; the following snap shows moved=1 and a position advanced by 1.
